// File: rtl/ifid_pipe_reg_if.sv
// IF/ID beat interface: carries the fetch-side (in_*) and decode-side (out_*)
// handshakes of the IF/ID pipeline stage register.
// master = the environment around the stage (fetch drives in_*, decode drives out_ready).
// slave  = the stage itself.
interface ifid_pipe_reg_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int LANES   = 1
);
    // Upstream (fetch -> stage)
    logic                       in_valid;
    logic                       in_ready;
    logic [LANES*ADDR_W-1:0]    in_addr;
    logic [LANES*INSTR_W-1:0]   in_instr;
    logic [LANES-1:0]           in_lane_vld;

    // Downstream (stage -> decode)
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*ADDR_W-1:0]    out_addr;
    logic [LANES*INSTR_W-1:0]   out_instr;
    logic [LANES-1:0]           out_lane_vld;

    modport master (
        output in_valid, in_addr, in_instr, in_lane_vld, out_ready,
        input  in_ready, out_valid, out_addr, out_instr, out_lane_vld
    );

    modport slave (
        input  in_valid, in_addr, in_instr, in_lane_vld, out_ready,
        output in_ready, out_valid, out_addr, out_instr, out_lane_vld
    );
endinterface

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline stage register with LANES fetch lanes, valid/ready handshake
// and a 2-entry (head + skid) buffer. in_ready is registered so the upstream
// handshake never sees a combinational path from decode, hold or flush.
// Optional statistics counters are built when IFID_PIPE_STATS_EN is defined.
module ifid_pipe_reg #(
    parameter int                  ADDR_W  = 32,
    parameter int                  INSTR_W = 32,
    parameter int                  LANES   = 1,
    parameter logic [INSTR_W-1:0]  NOP     = '0,
    parameter int                  CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                hold,
    ifid_pipe_reg_if.slave      bus
`ifdef IFID_PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0]    stat_stall_cnt,
    output logic [CNT_W-1:0]    stat_flush_cnt
`endif
);

    localparam int AW = LANES * ADDR_W;
    localparam int IW = LANES * INSTR_W;

    // Reject configurations the datapath was not built for.
    if (LANES < 1 || LANES > 4) begin : g_bad_lanes
        $error("ifid_pipe_reg: LANES must be in 1..4");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("ifid_pipe_reg: CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic               in_ready_reg, in_ready_next;

    logic [AW-1:0]      head_addr_reg;
    logic [IW-1:0]      head_instr_reg;
    logic [LANES-1:0]   head_lane_reg;
    logic [AW-1:0]      skid_addr_reg;
    logic [IW-1:0]      skid_instr_reg;
    logic [LANES-1:0]   skid_lane_reg;

    logic               acc;
    logic               deq;
    logic               out_valid_w;
    logic               head_load_in;
    logic               head_load_skid;
    logic               skid_load;

    assign out_valid_w = (state_reg != EMPTY);
    assign acc         = bus.in_valid & in_ready_reg;
    assign deq         = out_valid_w & bus.out_ready & ~hold;

    // Next-state and buffer-load decisions; flush wins over everything.
    always_comb begin
        state_next     = state_reg;
        head_load_in   = 1'b0;
        head_load_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            unique case (state_reg)
                EMPTY: begin
                    if (acc) begin
                        state_next   = ONE;
                        head_load_in = 1'b1;
                    end
                end
                ONE: begin
                    if (acc && deq) begin
                        head_load_in = 1'b1;
                    end else if (acc) begin
                        state_next = TWO;
                        skid_load  = 1'b1;
                    end else if (deq) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so no upstream beat can arrive.
                    if (deq) begin
                        state_next     = ONE;
                        head_load_skid = 1'b1;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
        in_ready_next = (state_next != TWO);
    end

    // State and registered in_ready; in_ready is low while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= EMPTY;
            in_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= in_ready_next;
        end
    end

    // Head register: loads from upstream or from the skid slot. The address
    // is kept when the stage empties so decode still sees the last PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_addr_reg  <= '0;
            head_instr_reg <= '0;
            head_lane_reg  <= '0;
        end else if (head_load_in) begin
            head_addr_reg  <= bus.in_addr;
            head_instr_reg <= bus.in_instr;
            head_lane_reg  <= bus.in_lane_vld;
        end else if (head_load_skid) begin
            head_addr_reg  <= skid_addr_reg;
            head_instr_reg <= skid_instr_reg;
            head_lane_reg  <= skid_lane_reg;
        end
    end

    // Skid register: captures the beat that arrives while the head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_addr_reg  <= '0;
            skid_instr_reg <= '0;
            skid_lane_reg  <= '0;
        end else if (skid_load) begin
            skid_addr_reg  <= bus.in_addr;
            skid_instr_reg <= bus.in_instr;
            skid_lane_reg  <= bus.in_lane_vld;
        end
    end

    assign bus.in_ready     = in_ready_reg;
    assign bus.out_valid    = out_valid_w;
    assign bus.out_addr     = head_addr_reg;
    assign bus.out_lane_vld = out_valid_w ? head_lane_reg : '0;

    // Each lane shows NOP whenever the stage holds no beat (reset, flush, drained).
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign bus.out_instr[gi*INSTR_W +: INSTR_W] =
            out_valid_w ? head_instr_reg[gi*INSTR_W +: INSTR_W] : NOP;
    end

`ifdef IFID_PIPE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;
    logic             stall_evt;
    logic             flush_evt;

    assign stall_evt = out_valid_w & (hold | ~bus.out_ready) & ~flush;
    assign flush_evt = flush & (state_reg != EMPTY);

    // Saturating event counters: stalled cycles and flushes that squash beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall_evt && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (flush_evt && (flush_cnt_reg != {CNT_W{1'b1}})) begin
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
        end
    end

    assign stat_stall_cnt = stall_cnt_reg;
    assign stat_flush_cnt = flush_cnt_reg;
`endif

endmodule
